// File: rtl/i2s_tx_serializer.sv
// I2S transmit serializer: holds one stereo pair and shifts it out MSB-first on sd,
// starting one clk after each ws transition (standard I2S one-bit delay).
module i2s_tx_serializer #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              en,
    input  logic              ws,
    input  logic              frame32,
    input  logic [DATA_W-1:0] tx_left,
    input  logic [DATA_W-1:0] tx_right,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              sd,
    output logic              underrun,
    output logic              active
);

    localparam int unsigned CNT_W    = 6;
    localparam int unsigned HALF_W   = 16;
    localparam logic [CNT_W-1:0] BITS_32 = CNT_W'(32);
    localparam logic [CNT_W-1:0] BITS_16 = CNT_W'(16);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    state_t             state;
    logic               ws_q;
    logic               hold_full;
    logic [DATA_W-1:0]  hold_l;
    logic [DATA_W-1:0]  hold_r;
    logic [DATA_W-1:0]  r_buf;
    logic [DATA_W-1:0]  shreg;
    logic               len32;
    logic [CNT_W-1:0]   bit_cnt;

    logic               chan_start;
    logic               left_start;
    logic [DATA_W-1:0]  left_word;
    logic [DATA_W-1:0]  left_al;
    logic [DATA_W-1:0]  right_al;
    logic [CNT_W-1:0]   slot_bits;

    // 16-bit words are left-justified so the MSB to send is always the top bit.
    function automatic logic [DATA_W-1:0] align(input logic [DATA_W-1:0] word, input logic is32);
        return is32 ? word : {word[HALF_W-1:0], {(DATA_W-HALF_W){1'b0}}};
    endfunction

    assign chan_start = ws ^ ws_q;
    assign left_start = chan_start & ~ws & en;
    assign left_word  = hold_full ? hold_l : '0;
    assign left_al    = align(left_word, frame32);
    assign right_al   = align(r_buf, len32);
    assign slot_bits  = len32 ? BITS_32 : BITS_16;
    assign tx_ready   = ~hold_full;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state     <= IDLE;
            ws_q      <= 1'b0;
            hold_full <= 1'b0;
            hold_l    <= '0;
            hold_r    <= '0;
            r_buf     <= '0;
            shreg     <= '0;
            len32     <= 1'b0;
            bit_cnt   <= '0;
            sd        <= 1'b0;
            underrun  <= 1'b0;
            active    <= 1'b0;
        end else begin
            ws_q     <= ws;
            underrun <= 1'b0;

            // A pair offered on a left-start edge lands in the holding register for the next frame.
            if (left_start && hold_full) begin
                hold_full <= 1'b0;
            end else if (tx_valid && !hold_full) begin
                hold_full <= 1'b1;
                hold_l    <= tx_left;
                hold_r    <= tx_right;
            end

            if (!en) begin
                state  <= IDLE;
                active <= 1'b0;
                sd     <= 1'b0;
            end else if (left_start) begin
                state    <= LEFT;
                active   <= 1'b1;
                len32    <= frame32;
                r_buf    <= hold_full ? hold_r : '0;
                shreg    <= {left_al[DATA_W-2:0], 1'b0};
                sd       <= left_al[DATA_W-1];
                bit_cnt  <= CNT_W'(1);
                underrun <= ~hold_full;
            end else begin
                case (state)
                    IDLE: sd <= 1'b0;
                    LEFT, RIGHT: begin
                        if (chan_start && ws && (state == LEFT)) begin
                            state   <= RIGHT;
                            shreg   <= {right_al[DATA_W-2:0], 1'b0};
                            sd      <= right_al[DATA_W-1];
                            bit_cnt <= CNT_W'(1);
                        end else begin
                            if (bit_cnt < slot_bits) begin
                                sd    <= shreg[DATA_W-1];
                                shreg <= {shreg[DATA_W-2:0], 1'b0};
                            end else begin
                                sd <= 1'b0;
                            end
                            if (bit_cnt != BITS_32) bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        active <= 1'b0;
                        sd     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
